pf_ddr4_dqs_delay_trainer: RTL

//  Per-lane DQS read-delay trainer. Drives the IOD delay-line controls (MOVE/DIRECTION/LOAD) and
//  eye-monitor clear of one DDR4 DQS lane. Sweeps taps from 0 upward, scoring each tap with
//  EYE_MONITOR_EARLY/LATE, and records the passing window [left,right]. It then steps back to the

---
 rtl/pf_ddr4_train_pkg.sv | 27 ++
 rtl/pf_ddr4_train_timer.sv | 31 +++
 rtl/pf_ddr4_dqs_delay_trainer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pf_ddr4_train_pkg.sv
// rtl/pf_ddr4_train_pkg.sv - shared state encoding and helpers for the DQS delay trainer
package pf_ddr4_train_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_CLEAR,
      S_SAMPLE,
      S_EVAL,
      S_STEP,
      S_CENTER,
      S_CMOVE,
      S_CWAIT,
      S_DONE,
      S_ERR
   } train_state_t;

   localparam logic TAP_PASS = 1'b1;
   localparam logic TAP_FAIL = 1'b0;

   // Width of a tap index for a delay line with max_taps positions.
   function automatic int tap_w(input int max_taps);
      return (max_taps > 1) ? $clog2(max_taps) : 1;
   endfunction

endpackage

// File: rtl/pf_ddr4_train_timer.sv
// rtl/pf_ddr4_train_timer.sv - loadable down-counter shared by settle, sample and centre waits
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_load           : load i_load_val into the counter
//   i_load_val       : wait length in cycles (>= 1)
//   o_expire         : high during the last cycle of the wait (counter == 1)
module pf_ddr4_train_timer #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_expire
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // Loading N yields exactly N cycles in the waiting state, the last one flagged here.
   assign o_expire = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/pf_ddr4_dqs_delay_trainer.sv
// rtl/pf_ddr4_dqs_delay_trainer.sv - per-lane DQS read-delay window sweep and centring
//   i_fab_clk, i_arst_n           : clock, async active-low reset
//   i_train_start                 : start pulse, accepted only when idle
//   o_train_busy/done/err         : run status; done and err are 1-cycle pulses
//   o_left_tap/o_right_tap        : first contiguous passing window
//   o_final_tap                   : tap currently applied to the delay line
//   o_delay_line_load/move/direction : IOD delay-line controls
//   o_eye_monitor_clear_flags     : clears the sticky eye flags before each sample window
//   i_eye_monitor_early/late      : sticky eye flags
//   i_delay_line_out_of_range     : IOD range fault
module pf_ddr4_dqs_delay_trainer
   import pf_ddr4_train_pkg::*;
#(
   parameter int MAX_TAPS   = 128,
   parameter int SETTLE_CYC = 8,
   parameter int SAMPLE_CYC = 64,
   localparam int TAP_W     = tap_w(MAX_TAPS)
) (
   input  logic             i_fab_clk,
   input  logic             i_arst_n,
   input  logic             i_train_start,
   output logic             o_train_busy,
   output logic             o_train_done,
   output logic             o_train_err,
   output logic [TAP_W-1:0] o_left_tap,
   output logic [TAP_W-1:0] o_right_tap,
   output logic [TAP_W-1:0] o_final_tap,
   output logic             o_delay_line_load,
   output logic             o_delay_line_move,
   output logic             o_delay_line_direction,
   output logic             o_eye_monitor_clear_flags,
   input  logic             i_eye_monitor_early,
   input  logic             i_eye_monitor_late,
   input  logic             i_delay_line_out_of_range
);

   localparam int CNT_MAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(MAX_TAPS - 1);

   train_state_t     r_state, w_state;
   logic [TAP_W-1:0] r_tap, w_tap;
   logic [TAP_W-1:0] r_left, w_left;
   logic [TAP_W-1:0] r_right, w_right;
   logic             r_found, w_found;
   logic             r_dir, w_dir;
   logic             r_pass, w_pass;

   logic             w_tmr_load;
   logic [CNT_W-1:0] w_tmr_val;
   logic             w_tmr_expire;
   logic [TAP_W:0]   w_sum;
   logic [TAP_W-1:0] w_target;

   // One extra bit so left+right cannot overflow before halving.
   assign w_sum    = {1'b0, r_left} + {1'b0, r_right};
   assign w_target = TAP_W'(w_sum >> 1);

   pf_ddr4_train_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .i_clk      (i_fab_clk),
      .i_rst_n    (i_arst_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_expire   (w_tmr_expire)
   );

   always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_state <= S_IDLE;
         r_tap   <= '0;
         r_left  <= '0;
         r_right <= '0;
         r_found <= 1'b0;
         r_dir   <= 1'b1;
         r_pass  <= TAP_FAIL;
      end else begin
         r_state <= w_state;
         r_tap   <= w_tap;
         r_left  <= w_left;
         r_right <= w_right;
         r_found <= w_found;
         r_dir   <= w_dir;
         r_pass  <= w_pass;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_tap      = r_tap;
      w_left     = r_left;
      w_right    = r_right;
      w_found    = r_found;
      w_dir      = r_dir;
      w_pass     = r_pass;
      w_tmr_load = 1'b0;
      w_tmr_val  = CNT_W'(SETTLE_CYC);
      o_train_busy              = 1'b1;
      o_train_done              = 1'b0;
      o_train_err               = 1'b0;
      o_delay_line_load         = 1'b0;
      o_delay_line_move         = 1'b0;
      o_eye_monitor_clear_flags = 1'b0;

      case (r_state)
         S_IDLE: begin
            o_train_busy = 1'b0;
            if (i_train_start) w_state = S_LOAD;
         end
         S_LOAD: begin
            o_delay_line_load = 1'b1;
            w_tap      = '0;
            w_found    = 1'b0;
            w_dir      = 1'b1;
            w_tmr_load = 1'b1;
            w_state    = S_SETTLE;
         end
         S_SETTLE: begin
            if (w_tmr_expire) w_state = S_CLEAR;
         end
         S_CLEAR: begin
            o_eye_monitor_clear_flags = 1'b1;
            w_tmr_load = 1'b1;
            w_tmr_val  = CNT_W'(SAMPLE_CYC);
            w_state    = S_SAMPLE;
         end
         S_SAMPLE: begin
            // Flags are sticky, so only the final cycle of the window matters.
            if (w_tmr_expire) begin
               w_pass  = (!i_eye_monitor_early && !i_eye_monitor_late) ? TAP_PASS : TAP_FAIL;
               w_state = S_EVAL;
            end
         end
         S_EVAL: begin
            if (r_pass == TAP_PASS) begin
               if (!r_found) begin
                  w_left  = r_tap;
                  w_found = 1'b1;
               end
               w_right = r_tap;
            end
            if ((r_pass == TAP_FAIL) && r_found) begin
               w_state = S_CENTER;
            end else if (r_tap == LAST_TAP) begin
               w_state = (r_found || (r_pass == TAP_PASS)) ? S_CENTER : S_ERR;
            end else begin
               w_state = S_STEP;
            end
         end
         S_STEP: begin
            o_delay_line_move = 1'b1;
            w_tap      = r_tap + TAP_ONE;
            w_tmr_load = 1'b1;
            w_state    = S_SETTLE;
         end
         S_CENTER: begin
            w_dir   = 1'b0;
            w_state = (r_tap == w_target) ? S_DONE : S_CMOVE;
         end
         S_CMOVE: begin
            o_delay_line_move = 1'b1;
            w_tap      = r_tap - TAP_ONE;
            w_tmr_load = 1'b1;
            w_state    = S_CWAIT;
         end
         S_CWAIT: begin
            // Deciding on the expire cycle gives one MOVE every SETTLE_CYC+1 cycles.
            if (w_tmr_expire) w_state = (r_tap == w_target) ? S_DONE : S_CMOVE;
         end
         S_DONE: begin
            o_train_busy = 1'b0;
            o_train_done = 1'b1;
            w_state      = S_IDLE;
         end
         S_ERR: begin
            o_train_busy = 1'b0;
            o_train_err  = 1'b1;
            w_state      = S_IDLE;
         end
         default: begin
            o_train_busy = 1'b0;
            w_state      = S_IDLE;
         end
      endcase

      // Range fault: a live window is truncated at the last good tap, otherwise the run aborts.
      // With a window already open, a fault seen in EVAL/STEP is picked up in the next SETTLE.
      if (i_delay_line_out_of_range && !(r_state inside {S_IDLE, S_DONE, S_ERR})) begin
         if (!r_found || (r_state inside {S_LOAD, S_CENTER, S_CMOVE, S_CWAIT})) begin
            w_state = S_ERR;
         end else if (r_state inside {S_SETTLE, S_CLEAR, S_SAMPLE}) begin
            w_right = r_tap - TAP_ONE;
            w_state = S_CENTER;
         end
      end
   end

   assign o_left_tap             = r_left;
   assign o_right_tap            = r_right;
   assign o_final_tap            = r_tap;
   assign o_delay_line_direction = r_dir;

endmodule
